// File: rtl/calc_core_if.sv
// Key-event and display-side bus of the calculator core.
// The master drives the key events; the slave (calc_core) drives the display value and flags.
interface calc_core_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [13:0] display_nr;
  logic        err;
  logic        busy;

  modport master (output key_valid, key_code, input display_nr, err, busy);
  modport slave  (input key_valid, key_code, output display_nr, err, busy);
endinterface

// File: rtl/calc_core.sv
// calc_core: key-entry FSM with 1-cycle add/sub and iterative multiply/divide feeding the display stage.
// Define CALC_DIV_EN to include the divide operator (key 13) and the restoring divider.
module calc_core #(
  parameter int unsigned MAX_VAL     = 9999,
  parameter int unsigned ITER_CYCLES = 14
) (
  input  logic       clk,
  input  logic       reset,
  calc_core_if.slave bus
);
  localparam int unsigned W  = 14;
  localparam int unsigned SW = W + 1;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned EW = 18;
  localparam int unsigned CW = $clog2(ITER_CYCLES + 1);

  typedef enum logic [2:0] {ENTRY_A, ENTRY_B, EXEC, RESULT, ERROR} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d, key_op_c;
  logic [W-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;
  logic [W-1:0]  disp_q, disp_d, mplier_q, mplier_d;
  logic          be_q, be_d, err_q, busy_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step_c;
`ifdef CALC_DIV_EN
  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, quo_step_c;
  logic [SW-1:0] rem_sh_c, rem_step_c;
  logic          ge_c;
`endif
  logic          is_digit_c, is_op_c, is_eq_c, is_clr_c;
  logic [EW-1:0] a_ent_c, b_ent_c;
  logic [SW-1:0] sum_c;
  logic          exec_fail_c;
  logic [W-1:0]  exec_res_c;

  // Key decode and decimal-entry candidates
  always_comb begin
    is_digit_c = bus.key_valid && (bus.key_code <= 4'd9);
    is_eq_c    = bus.key_valid && (bus.key_code == 4'd14);
    is_clr_c   = bus.key_valid && (bus.key_code == 4'd15);
`ifdef CALC_DIV_EN
    is_op_c    = bus.key_valid && (bus.key_code >= 4'd10) && (bus.key_code <= 4'd13);
`else
    is_op_c    = bus.key_valid && (bus.key_code >= 4'd10) && (bus.key_code <= 4'd12);
`endif
    key_op_c   = op_e'(2'(bus.key_code - 4'd10));
    a_ent_c    = EW'(a_q) * EW'(10) + EW'(bus.key_code);
    b_ent_c    = EW'(b_q) * EW'(10) + EW'(bus.key_code);
  end

  // One iteration step of each unit, plus the end-of-EXEC result and error check
  always_comb begin
    acc_step_c = mplier_q[0] ? acc_q + mcand_q : acc_q;
    sum_c      = SW'(a_q) + SW'(b_q);
`ifdef CALC_DIV_EN
    rem_sh_c   = {rem_q, quo_q[W-1]};
    ge_c       = rem_sh_c >= SW'(b_q);
    rem_step_c = ge_c ? rem_sh_c - SW'(b_q) : rem_sh_c;
    quo_step_c = {quo_q[W-2:0], ge_c};
`endif
    exec_fail_c = 1'b0;
    exec_res_c  = '0;
    case (op_q)
      OP_ADD: begin exec_fail_c = sum_c > SW'(MAX_VAL);      exec_res_c = W'(sum_c);      end
      OP_SUB: begin exec_fail_c = a_q < b_q;                 exec_res_c = a_q - b_q;      end
      OP_MUL: begin exec_fail_c = acc_step_c > PW'(MAX_VAL); exec_res_c = W'(acc_step_c); end
`ifdef CALC_DIV_EN
      OP_DIV: begin exec_fail_c = (b_q == '0);               exec_res_c = quo_step_c;     end
`endif
      default: ;
    endcase
  end

  // Next-state, datapath and registered-output selection
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef CALC_DIV_EN
    rem_d    = rem_q;
    quo_d    = quo_q;
`endif
    if (is_clr_c) begin
      state_d = ENTRY_A;
      op_d    = OP_ADD;
      a_d     = '0;
      b_d     = '0;
      be_d    = 1'b0;
    end else begin
      case (state_q)
        ENTRY_A: begin
          if (is_digit_c) begin
            if (a_ent_c <= EW'(MAX_VAL)) a_d = W'(a_ent_c);
          end else if (is_op_c) begin
            op_d    = key_op_c;
            b_d     = '0;
            be_d    = 1'b0;
            state_d = ENTRY_B;
          end
        end
        ENTRY_B: begin
          if (is_digit_c) begin
            if (b_ent_c <= EW'(MAX_VAL)) b_d = W'(b_ent_c);
            be_d = 1'b1;
          end else if (is_op_c) begin
            if (!be_q) op_d = key_op_c;
          end else if (is_eq_c) begin
            state_d  = EXEC;
            b_d      = be_q ? b_q : '0;
            acc_d    = '0;
            mcand_d  = PW'(a_q);
            mplier_d = be_q ? b_q : '0;
`ifdef CALC_DIV_EN
            rem_d    = '0;
            quo_d    = a_q;
`endif
            cnt_d    = (op_q == OP_MUL || op_q == OP_DIV) ? CW'(ITER_CYCLES - 1) : '0;
          end
        end
        EXEC: begin
          // The last cycle folds its own iteration step into the result check
          if (cnt_q == '0) begin
            state_d = exec_fail_c ? ERROR : RESULT;
            r_d     = exec_fail_c ? r_q : exec_res_c;
          end else begin
            cnt_d    = cnt_q - CW'(1);
            acc_d    = acc_step_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
`ifdef CALC_DIV_EN
            rem_d    = W'(rem_step_c);
            quo_d    = quo_step_c;
`endif
          end
        end
        RESULT: begin
          if (is_digit_c) begin
            a_d     = W'(bus.key_code);
            b_d     = '0;
            be_d    = 1'b0;
            state_d = ENTRY_A;
          end else if (is_op_c) begin
            a_d     = r_q;
            op_d    = key_op_c;
            b_d     = '0;
            be_d    = 1'b0;
            state_d = ENTRY_B;
          end
        end
        default: ;
      endcase
    end

    disp_d = disp_q;
    case (state_d)
      ENTRY_A: disp_d = a_d;
      ENTRY_B: disp_d = be_d ? b_d : a_d;
      RESULT:  disp_d = r_d;
      ERROR:   disp_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ENTRY_A;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      be_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`ifdef CALC_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
`endif
      disp_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`ifdef CALC_DIV_EN
      rem_q    <= rem_d;
      quo_q    <= quo_d;
`endif
      disp_q   <= disp_d;
      err_q    <= (state_d == ERROR);
      busy_q   <= (state_d == EXEC);
    end
  end

  assign bus.display_nr = disp_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core: key presses queue the expected next-cycle outputs,
// operations queue the expected result and busy length; a monitor pops and compares.
module tb_calc_core;
  logic clk = 1'b0;
  logic reset;
  calc_core_if bus();

  calc_core dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { int d; bit e; bit b; } kexp_t;
  typedef struct { int d; bit e; int n; } rexp_t;

  kexp_t kq[$];
  rexp_t rq[$];
  int    total = 0;
  int    bad   = 0;
  int    kidx  = 0;

  task automatic press(input int code, input int d, input bit e, input bit b);
    kexp_t x;
    x.d = d; x.e = e; x.b = b;
    kq.push_back(x);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(code);
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic expect_result(input int d, input bit e, input int n);
    rexp_t x;
    x.d = d; x.e = e; x.n = n;
    rq.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_key();
    kexp_t x;
    total++;
    kidx++;
    if (kq.size() == 0) begin
      bad++;
      $display("FAIL key#%0d: response with no expected entry", kidx);
    end else begin
      x = kq.pop_front();
      if (bus.display_nr !== 14'(x.d) || bus.err !== x.e || bus.busy !== x.b) begin
        bad++;
        $display("FAIL key#%0d: got disp=%0d err=%0b busy=%0b, want disp=%0d err=%0b busy=%0b",
                 kidx, bus.display_nr, bus.err, bus.busy, x.d, x.e, x.b);
      end
    end
  endtask

  task automatic check_res(input int n);
    rexp_t x;
    total++;
    if (rq.size() == 0) begin
      bad++;
      $display("FAIL result: busy fell after %0d cycles with no expected entry", n);
    end else begin
      x = rq.pop_front();
      if (bus.display_nr !== 14'(x.d) || bus.err !== x.e || n != x.n) begin
        bad++;
        $display("FAIL result: got disp=%0d err=%0b busy_cycles=%0d, want disp=%0d err=%0b busy_cycles=%0d",
                 bus.display_nr, bus.err, n, x.d, x.e, x.n);
      end
    end
  endtask

  // Monitor: key responses one cycle after acceptance; results when busy falls
  initial begin : monitor
    bit took;
    bit prev_busy;
    int bcnt;
    prev_busy = 1'b0;
    bcnt      = 0;
    forever begin
      @(posedge clk);
      took = bus.key_valid;
      @(negedge clk);
      if (!reset) begin
        prev_busy = 1'b0;
        bcnt      = 0;
      end else begin
        if (took) check_key();
        if (bus.busy) bcnt++;
        else if (prev_busy) begin
          check_res(bcnt);
          bcnt = 0;
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin
    reset         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    idle(3);
    total++;
    if (bus.display_nr !== 14'd0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: got disp=%0d err=%0b busy=%0b, want 0 0 0", bus.display_nr, bus.err, bus.busy);
    end
    reset = 1'b1;
    idle(2);

    // Entry limit: fifth digit ignored
    press(1, 1, 0, 0); press(2, 12, 0, 0); press(3, 123, 0, 0);
    press(4, 1234, 0, 0); press(5, 1234, 0, 0); press(15, 0, 0, 0);
    // Equals in ENTRY_A ignored; leading zero keeps 0
    press(14, 0, 0, 0); press(0, 0, 0, 0);

    // 25 + 17
    press(2, 2, 0, 0); press(5, 25, 0, 0); press(10, 25, 0, 0);
    press(1, 1, 0, 0); press(7, 17, 0, 0);
    expect_result(42, 0, 1);
    press(14, 17, 0, 1);
    idle(3);
    press(14, 42, 0, 0); press(15, 0, 0, 0);

    // 99 * 101, with a digit dropped during EXEC
    press(9, 9, 0, 0); press(9, 99, 0, 0); press(12, 99, 0, 0);
    press(1, 1, 0, 0); press(0, 10, 0, 0); press(1, 101, 0, 0);
    expect_result(9999, 0, 14);
    press(14, 101, 0, 1);
    press(3, 101, 0, 1);
    idle(18);
    press(15, 0, 0, 0);

    // 100 * 100 overflows
    press(1, 1, 0, 0); press(0, 10, 0, 0); press(0, 100, 0, 0); press(12, 100, 0, 0);
    press(1, 1, 0, 0); press(0, 10, 0, 0); press(0, 100, 0, 0);
    expect_result(0, 1, 14);
    press(14, 100, 0, 1);
    idle(18);
    press(5, 0, 1, 0); press(15, 0, 0, 0);

    // 5 - 7 underflows
    press(5, 5, 0, 0); press(11, 5, 0, 0); press(7, 7, 0, 0);
    expect_result(0, 1, 1);
    press(14, 7, 0, 1);
    idle(3);
    press(15, 0, 0, 0);

    // Operator replacement before B, ignored after B: 8 sub 3 = 5
    press(8, 8, 0, 0); press(10, 8, 0, 0); press(11, 8, 0, 0);
    press(3, 3, 0, 0); press(12, 3, 0, 0);
    expect_result(5, 0, 1);
    press(14, 3, 0, 1);
    idle(3);
    press(15, 0, 0, 0);

    // Equals with no B entered: 4 + 0
    press(4, 4, 0, 0); press(10, 4, 0, 0);
    expect_result(4, 0, 1);
    press(14, 4, 0, 1);
    idle(3);
    press(15, 0, 0, 0);

    // Chaining: 6 * 7 = 42, + 8 = 50, then a digit starts fresh
    press(6, 6, 0, 0); press(12, 6, 0, 0); press(7, 7, 0, 0);
    expect_result(42, 0, 14);
    press(14, 7, 0, 1);
    idle(18);
    press(10, 42, 0, 0); press(8, 8, 0, 0);
    expect_result(50, 0, 1);
    press(14, 8, 0, 1);
    idle(3);
    press(3, 3, 0, 0); press(15, 0, 0, 0);

`ifdef CALC_DIV_EN
    press(9, 9, 0, 0); press(13, 9, 0, 0); press(2, 2, 0, 0); press(15, 0, 0, 0);
    // 9999 / 0
    press(9, 9, 0, 0); press(9, 99, 0, 0); press(9, 999, 0, 0); press(9, 9999, 0, 0);
    press(13, 9999, 0, 0); press(0, 0, 0, 0);
    expect_result(0, 1, 14);
    press(14, 0, 0, 1);
    idle(18);
    press(15, 0, 0, 0);
    // 100 / 7
    press(1, 1, 0, 0); press(0, 10, 0, 0); press(0, 100, 0, 0);
    press(13, 100, 0, 0); press(7, 7, 0, 0);
    expect_result(14, 0, 14);
    press(14, 7, 0, 1);
    idle(18);
    press(15, 0, 0, 0);
`else
    // Key 13 ignored: still entering A
    press(9, 9, 0, 0); press(13, 9, 0, 0); press(2, 92, 0, 0); press(15, 0, 0, 0);
`endif

    // Clear on the 5th busy cycle of 1234 * 8
    press(1, 1, 0, 0); press(2, 12, 0, 0); press(3, 123, 0, 0); press(4, 1234, 0, 0);
    press(12, 1234, 0, 0); press(8, 8, 0, 0);
    expect_result(0, 0, 5);
    press(14, 8, 0, 1);
    idle(3);
    press(15, 0, 0, 0);
    idle(3);

    // Asynchronous reset mid-EXEC
    press(1, 1, 0, 0); press(2, 12, 0, 0); press(12, 12, 0, 0); press(3, 3, 0, 0);
    press(14, 3, 0, 1);
    idle(3);
    #2 reset = 1'b0;
    #1;
    total++;
    if (bus.display_nr !== 14'd0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got disp=%0d err=%0b busy=%0b, want 0 0 0", bus.display_nr, bus.err, bus.busy);
    end
    idle(2);
    reset = 1'b1;
    idle(2);
    press(7, 7, 0, 0);
    idle(20);

    total++;
    if (kq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL drain: got key_left=%0d result_left=%0d, want 0 0", kq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
